cache_refill_ctrl: RTL and testbench

Direct-mapped read-cache front end that sits upstream of the line-fill path: it receives CPU read requests, performs tag/valid lookup, returns hit data, and on a miss stalls the CPU, issues one memory word request per line word, fills the line from in-order memory responses, then replays the missed access. It owns the tag, valid and data arrays and is the only writer of them.

---
 rtl/cache_refill_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Direct-mapped read cache front end. Performs tag/valid lookup
//               on CPU reads, returns hit data, and on a miss stalls the CPU,
//               refills the line one word at a time from memory, then replays
//               the missed access.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int INDEX  = 10,
    parameter int OFFSET = 3,
    parameter int TAG    = 32 - INDEX - OFFSET - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        inval_all,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int LINES  = 1 << INDEX;
    localparam int WORDS  = 1 << OFFSET;
    localparam int LINE_W = TAG + INDEX;

    // Counters carry one extra bit so "all words issued" is simply the MSB.
    localparam logic [OFFSET:0] c_cnt_one  = {{OFFSET{1'b0}}, 1'b1};
    localparam logic [OFFSET:0] c_cnt_last = {1'b0, {OFFSET{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG-1:0]     r_tag  [LINES];
    logic [31:0]        r_data [LINES*WORDS];
    logic [LINE_W-1:0]  r_line;
    logic [OFFSET-1:0]  r_off;
    logic [OFFSET:0]    r_issue_cnt;
    logic [OFFSET:0]    r_resp_cnt;
    logic               r_inval_pend;

    logic [INDEX-1:0]   w_idx;
    logic [TAG-1:0]     w_tag;
    logic [OFFSET-1:0]  w_off;
    logic               w_lookup;
    logic               w_hit;
    logic               w_miss;
    logic [INDEX-1:0]   w_fill_idx;
    logic [TAG-1:0]     w_fill_tag;
    logic               w_fill_we;
    logic               w_fill_last;
    logic [OFFSET:0]    w_issue_next;
    logic [31:0]        w_replay_data;
    logic               w_unused_addr;

    assign w_idx         = cpu_addr[INDEX+OFFSET+1:OFFSET+2];
    assign w_tag         = cpu_addr[31:INDEX+OFFSET+2];
    assign w_off         = cpu_addr[OFFSET+1:2];
    assign w_unused_addr = &{1'b0, cpu_addr[1:0]};

    assign w_lookup = (r_state == ST_IDLE) && cpu_req;
    assign w_hit    = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss   = w_lookup && !(r_valid[w_idx] && (r_tag[w_idx] == w_tag));

    assign w_fill_idx   = r_line[INDEX-1:0];
    assign w_fill_tag   = r_line[LINE_W-1:INDEX];
    assign w_fill_we    = (r_state == ST_REFILL) && mem_rvalid;
    assign w_fill_last  = w_fill_we && (r_resp_cnt == c_cnt_last);
    assign w_issue_next = r_issue_cnt + c_cnt_one;

    // The last word is written on the same edge the replay data is captured,
    // so it has to be taken straight from the response bus.
    assign w_replay_data = (r_off == {OFFSET{1'b1}}) ? mem_rdata
                                                     : r_data[{w_fill_idx, r_off}];

    // Stall rises in the miss cycle itself and is forced low while in reset.
    assign cpu_stall = reset && (w_miss || (r_state == ST_REFILL));

    // Tag and data arrays: written only by the refill path, never reset.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_fill_idx, r_resp_cnt[OFFSET-1:0]}] <= mem_rdata;
        end
        if (w_fill_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

    // Control FSM: lookup, word-by-word refill, replay, valid-bit management.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_line       <= '0;
            r_off        <= '0;
            r_issue_cnt  <= '0;
            r_resp_cnt   <= '0;
            r_inval_pend <= 1'b0;
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (inval_all) begin
                        r_valid <= '0;
                    end else if (w_miss) begin
                        r_valid[w_idx] <= 1'b0;
                    end
                    if (w_hit) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= r_data[{w_idx, w_off}];
                    end else if (w_miss) begin
                        r_line      <= cpu_addr[31:OFFSET+2];
                        r_off       <= w_off;
                        r_issue_cnt <= '0;
                        r_resp_cnt  <= '0;
                        mem_req     <= 1'b1;
                        mem_addr    <= {cpu_addr[31:OFFSET+2], {OFFSET{1'b0}}, 2'b00};
                        r_state     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (inval_all) begin
                        r_inval_pend <= 1'b1;
                    end
                    if (mem_req && mem_ready) begin
                        r_issue_cnt <= w_issue_next;
                        mem_req     <= ~w_issue_next[OFFSET];
                        mem_addr    <= {r_line, w_issue_next[OFFSET-1:0], 2'b00};
                    end
                    if (w_fill_we) begin
                        r_resp_cnt <= r_resp_cnt + c_cnt_one;
                        if (w_fill_last) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            cpu_rvalid          <= 1'b1;
                            cpu_rdata           <= w_replay_data;
                            r_state             <= ST_REPLAY;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (r_inval_pend || inval_all) begin
                        r_valid <= '0;
                    end
                    r_inval_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Directed self-checking bench for cache_refill_ctrl: miss and
//               refill, hits, conflicts, memory backpressure, invalidation and
//               reset in the middle of a refill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        inval_all;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    cache_refill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .inval_all  (inval_all),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a read that must miss; stall must rise in the same cycle.
    task automatic start_miss(input logic [31:0] addr);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        check("miss_stall", {31'd0, cpu_stall}, 32'd1);
    endtask

    // Read that must hit: no stall, data one cycle later.
    task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        #1;
        check("hit_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        check("hit_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("hit_rdata", cpu_rdata, exp);
        cpu_req = 1'b0;
    endtask

    // Memory model for one refill. Word k of the line returns dbase+k, one
    // cycle after its request is accepted. ready_mode 1 toggles mem_ready
    // 1,0,1,0... ; abort_after>0 stops after that many responses.
    task automatic refill(input logic [31:0] line_base, input logic [31:0] dbase,
                          input int ready_mode, input int abort_after,
                          input logic pulse_inval, input logic [31:0] exp_rdata);
        logic [31:0] q[$];
        int issued   = 0;
        int answered = 0;
        int cyc      = 0;
        logic rdy;
        while (answered < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("refill_stall", {31'd0, cpu_stall}, 32'd1);
            check("refill_mem_req", {31'd0, mem_req}, (issued < 8) ? 32'd1 : 32'd0);
            if (mem_req && issued < 8)
                check("refill_mem_addr", mem_addr, line_base + 32'(issued * 4));
            mem_rvalid = 1'b0;
            if (q.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q.pop_front();
                answered++;
            end
            rdy       = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            mem_ready = rdy;
            if (rdy && mem_req && issued < 8) begin
                q.push_back(dbase + 32'(issued));
                issued++;
            end
            inval_all = pulse_inval && (cyc == 3);
            if (abort_after > 0 && answered == abort_after) break;
        end
        if (abort_after == 0) begin
            if (answered < 8)
                check("refill_timeout", 32'(answered), 32'd8);
            @(negedge clk);
            check("replay_rvalid", {31'd0, cpu_rvalid}, 32'd1);
            check("replay_rdata", cpu_rdata, exp_rdata);
            check("replay_stall", {31'd0, cpu_stall}, 32'd0);
            check("replay_mem_req", {31'd0, mem_req}, 32'd0);
            mem_rvalid = 1'b0;
            mem_ready  = 1'b0;
            inval_all  = 1'b0;
            cpu_req    = 1'b0;
            @(negedge clk);
            check("post_replay_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios.
    initial begin
        reset      = 1'b0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        inval_all  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;

        // Cold miss, offset 1 of line 0x100.
        start_miss(32'h0000_0104);
        refill(32'h0000_0100, 32'h0000_00A0, 0, 0, 1'b0, 32'h0000_00A1);

        // Back-to-back hits.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0118;
        #1;
        check("b2b_stall0", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        check("b2b_rvalid0", {31'd0, cpu_rvalid}, 32'd1);
        check("b2b_rdata0", cpu_rdata, 32'h0000_00A6);
        cpu_addr = 32'h0000_0100;
        #1;
        check("b2b_stall1", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        check("b2b_rvalid1", {31'd0, cpu_rvalid}, 32'd1);
        check("b2b_rdata1", cpu_rdata, 32'h0000_00A0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("b2b_idle_rvalid", {31'd0, cpu_rvalid}, 32'd0);

        // Conflict: 0x8104 shares index 8 with 0x104 but has another tag.
        start_miss(32'h0000_8104);
        refill(32'h0000_8100, 32'h0000_00B0, 0, 0, 1'b0, 32'h0000_00B1);
        // Evicted line misses again; refill under toggling mem_ready.
        start_miss(32'h0000_0104);
        refill(32'h0000_0100, 32'h0000_00A0, 1, 0, 1'b0, 32'h0000_00A1);
        hit(32'h0000_011C, 32'h0000_00A7);

        // Invalidate pulsed during refill: replay still returns data.
        start_miss(32'h0000_0204);
        refill(32'h0000_0200, 32'h0000_00D0, 0, 0, 1'b1, 32'h0000_00D1);
        start_miss(32'h0000_0204);
        refill(32'h0000_0200, 32'h0000_00D0, 0, 0, 1'b0, 32'h0000_00D1);
        hit(32'h0000_0208, 32'h0000_00D2);

        // Invalidate in IDLE together with a hit: hit data still returned.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0208;
        inval_all = 1'b1;
        #1;
        check("inval_hit_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        inval_all = 1'b0;
        check("inval_hit_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        check("inval_hit_rdata", cpu_rdata, 32'h0000_00D2);
        cpu_req = 1'b0;
        start_miss(32'h0000_0208);
        refill(32'h0000_0200, 32'h0000_00E0, 0, 0, 1'b0, 32'h0000_00E2);

        // Reset after three responses of a refill.
        start_miss(32'h0000_0304);
        refill(32'h0000_0300, 32'h0000_00F0, 0, 3, 1'b0, 32'h0000_0000);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
        reset      = 1'b0;
        #1;
        check("abort_stall", {31'd0, cpu_stall}, 32'd0);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stray_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("stray_mem_req", {31'd0, mem_req}, 32'd0);
        check("stray_stall", {31'd0, cpu_stall}, 32'd0);
        start_miss(32'h0000_0304);
        refill(32'h0000_0300, 32'h0000_00C0, 0, 0, 1'b0, 32'h0000_00C1);
        hit(32'h0000_031C, 32'h0000_00C7);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
